warp_rr_scheduler: RTL
======================

# warp_rr_scheduler

Parametrised next-generation warp scheduler for the compute unit: tracks `NUM_WARPS` warps, each with its own PC, one-entry instruction buffer and per-thread busy scoreboard. Each cycle it selects one issuable warp by round-robin and presents that warp's buffered instruction to the LSU over a valid/ready handshake. On the LSU completion port it clears busy threads, and it signals when every warp has halted and drained. It sits between instruction fetch/decode (upstream) and the LSU/threads register file (downstream).

## Interface
- `NUM_WARPS`, default 4: warp count, power of two, 2..16.
- `NUM_THREADS`, default 32: threads per warp, width of all thread masks.
- `PC_WIDTH`, default 8: PC width.
- `WID`, default `$clog2(NUM_WARPS)`: warp index width (derived; not overridden).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: launch pulse; all warps become active at `start_pc`.
- `start_pc` in PC_WIDTH: launch PC.
- `fetch_warp` in WID: warp whose PC is requested by fetch.
- `fetch_pc` out PC_WIDTH: combinational PC of `fetch_warp`.
- `buf_wr_en` in 1: write decoded instruction into a warp buffer.
- `buf_warp` in WID: target warp of the write.
- `buf_instr` in 14: {opcode[3:0], target_reg[3:0], address_reg[3:0], array_id[1:0]}.
- `buf_mask` in NUM_THREADS: thread mask of the instruction.
- `buf_halt` in 1: instruction ends the warp.
- `buf_full` out NUM_WARPS: per-warp buffer-occupied flags.
- `issue_valid` out 1: an instruction is offered.
- `issue_ready` in 1: LSU accepts.
- `issue_warp` out WID, `issue_instr` out 14, `issue_mask` out NUM_THREADS, `issue_pc` out PC_WIDTH: offered instruction.
- `clr_valid` in 1, `clr_warp` in WID, `clr_mask` in NUM_THREADS: LSU completion, clears busy threads.
- `all_done` out 1: every warp inactive and every busy mask zero.
- `overflow` out 1: sticky; a write hit a full buffer.

## Operation
- Per-warp state: `active`, `pc`, `buf_valid`, buffered instr/mask/halt, `busy[NUM_THREADS]`; plus round-robin pointer `rr_ptr`.
- Warp w is eligible when `active & buf_valid & ((buf_mask & busy) == 0)`.
- Arbiter: search starts at `rr_ptr` and wraps modulo NUM_WARPS. The first eligible warp drives the issue outputs. `issue_valid` = any eligible.
- Issue fire (`issue_valid & issue_ready`):
  - Set `busy |= buf_mask`.
  - Clear `buf_valid`.
  - `pc <= pc + 1`, wrapping mod 2^PC_WIDTH.
  - `rr_ptr <= issue_warp + 1`, wrapping.
  - If halt, `active <= 0`.
- Without a fire, `rr_ptr` holds. Offered outputs may change while `issue_ready` is low; the LSU samples them only on fire.
- Completion: `busy[clr_warp] &= ~clr_mask`. Bits already clear are ignored.
- Same-cycle fire and clear on the same warp: `busy_next = (busy & ~clr_mask) | issue_mask`.
- Buffer write: accepted when `buf_full[buf_warp]` is 0. The same-cycle issue of that warp frees the slot, so a write to it is also accepted that cycle. Any other write to a full buffer is dropped and sets `overflow`.
- Writes to inactive warps are accepted; the instruction issues only after the warp is activated.
- `start`:
  - Sets every warp active with `pc = start_pc`.
  - Clears buffers and `overflow`.
  - Does not touch `busy`, so in-flight LSU completions still clear.
  - Takes priority over a same-cycle issue or write; those are discarded.
- `all_done` = no warp active and all busy masks zero. It is 0 from the cycle after `start` until the condition recurs.
- Reset values: all warps inactive, PCs 0, buffers empty, busy 0, `rr_ptr` 0, `overflow` 0, `issue_valid` 0, `all_done` 1. Reset mid-operation abandons all in-flight state.

## Timing
- `issue_*` and `all_done` are combinational from registered state only. There is no input-to-output path except `fetch_warp` -> `fetch_pc`.
- Buffer write to earliest `issue_valid` for that warp: 1 cycle.
- Completion to re-eligibility of a blocked warp: 1 cycle, since busy is registered.
- PC increment is visible on `fetch_pc` the cycle after the fire.
- Back-to-back issue from different warps every cycle is supported. One warp issues at most once per buffer fill.

## Structure
- Shared header `warp_defs.vh`: instruction field widths and offsets (opcode 4, reg 4, array_id 2, packed width 14).
- Sub-module `rr_arbiter`, parameters N and WID:
  - Inputs: request vector and `rr_ptr`.
  - Outputs: grant index and `any`.
- Per-warp state lives in generate loops in the top level.

## Test plan
- Reset, then `start`, `start_pc`=0x10 -> all `fetch_pc` = 0x10, `issue_valid`=0, `all_done`=0.
- Fill buffers of warps 0..3 with disjoint masks, `issue_ready`=1 -> issues in order 0,1,2,3 on consecutive cycles; each warp's PC becomes 0x11.
- Warp 1 issues mask 0x0000_00FF; refill warp 1 with mask 0x0000_0001 -> held off; `clr_mask` 0xFF for warp 1 -> issue_valid for warp 1 the next cycle.
- Hold `issue_ready`=0 for 3 cycles with warps 2 and 3 eligible, `rr_ptr`=2 -> warp 2 offered throughout; on release warp 2 fires, then warp 3.
- Same-cycle fire and clear on warp 0 with overlapping masks -> busy equals the new mask. A second write to full warp 3 -> `overflow`=1, original entry kept.
- All warps issue halt, then LSU clears all masks -> `all_done`=1 exactly on the cycle after the last clear; PC 0xFF + issue wraps to 0x00.

Source files
------------

// File: rtl/warp_rr_scheduler_pkg.sv
// Shared definitions for the warp round-robin scheduler: instruction field
// layout and a small field-extraction helper.
package warp_rr_scheduler_pkg;

  // Instruction word layout: {opcode, target_reg, address_reg, array_id}
  localparam int OPCODE_W     = 4;
  localparam int REG_W        = 4;
  localparam int ARRAY_ID_W   = 2;
  localparam int INSTR_W      = OPCODE_W + 2 * REG_W + ARRAY_ID_W;

  localparam int ARRAY_ID_LSB = 0;
  localparam int ADDR_REG_LSB = ARRAY_ID_LSB + ARRAY_ID_W;
  localparam int TGT_REG_LSB  = ADDR_REG_LSB + REG_W;
  localparam int OPCODE_LSB   = TGT_REG_LSB + REG_W;

  typedef logic [INSTR_W-1:0] instr_t;

  // Pull the opcode field out of a packed instruction word
  function automatic logic [OPCODE_W-1:0] instr_opcode(input instr_t i_instr);
    return i_instr[OPCODE_LSB +: OPCODE_W];
  endfunction

endpackage

// File: rtl/warp_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// wrapping modulo N (N is a power of two, so WID-bit addition wraps).
module rr_arbiter #(
  parameter int N   = 4,
  parameter int WID = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [WID-1:0] i_rr_ptr,
  output logic [WID-1:0] o_grant,
  output logic           o_any
);

  logic [WID-1:0] w_idx;
  logic           w_found;

  // Scan requesters starting at the round-robin pointer; first hit wins
  always_comb begin
    o_grant = {WID{1'b0}};
    w_found = 1'b0;
    w_idx   = {WID{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_idx = i_rr_ptr + WID'(i);
      if (!w_found && i_req[w_idx]) begin
        o_grant = w_idx;
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/warp_rr_scheduler.sv
// Warp scheduler: per-warp PC, one-entry instruction buffer and busy
// scoreboard; round-robin issue of eligible warps to the LSU.
module warp_rr_scheduler
  import warp_rr_scheduler_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 32,
  parameter int PC_WIDTH    = 8,
  parameter int WID         = $clog2(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    start_pc,
  input  logic [WID-1:0]         fetch_warp,
  output logic [PC_WIDTH-1:0]    fetch_pc,
  input  logic                   buf_wr_en,
  input  logic [WID-1:0]         buf_warp,
  input  logic [INSTR_W-1:0]     buf_instr,
  input  logic [NUM_THREADS-1:0] buf_mask,
  input  logic                   buf_halt,
  output logic [NUM_WARPS-1:0]   buf_full,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [WID-1:0]         issue_warp,
  output logic [INSTR_W-1:0]     issue_instr,
  output logic [NUM_THREADS-1:0] issue_mask,
  output logic [PC_WIDTH-1:0]    issue_pc,
  input  logic                   clr_valid,
  input  logic [WID-1:0]         clr_warp,
  input  logic [NUM_THREADS-1:0] clr_mask,
  output logic                   all_done,
  output logic                   overflow
);

  logic [NUM_WARPS-1:0]   w_active;
  logic [NUM_WARPS-1:0]   w_buf_valid;
  logic [NUM_WARPS-1:0]   w_eligible;
  logic [NUM_WARPS-1:0]   w_busy_nz;
  logic [PC_WIDTH-1:0]    w_pc        [NUM_WARPS];
  instr_t                 w_buf_instr [NUM_WARPS];
  logic [NUM_THREADS-1:0] w_buf_mask  [NUM_WARPS];

  logic [WID-1:0]         r_rr_ptr;
  logic                   r_overflow;
  logic [WID-1:0]         w_grant;
  logic                   w_any;
  logic                   w_fire;
  logic                   w_ovf_set;

  rr_arbiter #(
    .N   (NUM_WARPS),
    .WID (WID)
  ) u_rr_arbiter (
    .i_req    (w_eligible),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

  assign w_fire = w_any & issue_ready;

  genvar w;
  generate
    for (w = 0; w < NUM_WARPS; w++) begin : g_warp
      logic                   r_active;
      logic [PC_WIDTH-1:0]    r_pc;
      logic                   r_buf_valid;
      instr_t                 r_buf_instr;
      logic [NUM_THREADS-1:0] r_buf_mask;
      logic                   r_buf_halt;
      logic [NUM_THREADS-1:0] r_busy;
      logic                   w_sel_fire;
      logic                   w_sel_clr;
      logic                   w_wr_ok;
      logic [NUM_THREADS-1:0] w_busy_clr;
      logic [NUM_THREADS-1:0] w_busy_next;

      assign w_sel_fire  = w_fire && (w_grant == WID'(w));
      assign w_sel_clr   = clr_valid && (clr_warp == WID'(w));
      // A full buffer still accepts a write when it is being issued this cycle
      assign w_wr_ok     = buf_wr_en && (buf_warp == WID'(w)) && (!r_buf_valid || w_sel_fire);
      assign w_busy_clr  = r_busy & ~(w_sel_clr ? clr_mask : {NUM_THREADS{1'b0}});
      assign w_busy_next = w_busy_clr | (w_sel_fire ? r_buf_mask : {NUM_THREADS{1'b0}});

      // Per-warp state: launch, issue side effects, buffer fill and busy tracking
      always_ff @(posedge clk) begin
        if (reset) begin
          r_active    <= 1'b0;
          r_pc        <= {PC_WIDTH{1'b0}};
          r_buf_valid <= 1'b0;
          r_buf_instr <= {INSTR_W{1'b0}};
          r_buf_mask  <= {NUM_THREADS{1'b0}};
          r_buf_halt  <= 1'b0;
          r_busy      <= {NUM_THREADS{1'b0}};
        end else if (start) begin
          // Launch discards same-cycle issue/write but keeps in-flight busy bits
          r_active    <= 1'b1;
          r_pc        <= start_pc;
          r_buf_valid <= 1'b0;
          r_busy      <= w_busy_clr;
        end else begin
          r_busy <= w_busy_next;
          if (w_sel_fire) begin
            r_pc <= r_pc + PC_WIDTH'(1);
            if (r_buf_halt) begin
              r_active <= 1'b0;
            end else begin
              r_active <= r_active;
            end
          end else begin
            r_pc <= r_pc;
          end
          if (w_wr_ok) begin
            r_buf_valid <= 1'b1;
            r_buf_instr <= buf_instr;
            r_buf_mask  <= buf_mask;
            r_buf_halt  <= buf_halt;
          end else if (w_sel_fire) begin
            r_buf_valid <= 1'b0;
          end else begin
            r_buf_valid <= r_buf_valid;
          end
        end
      end

      assign w_active[w]    = r_active;
      assign w_buf_valid[w] = r_buf_valid;
      assign w_eligible[w]  = r_active & r_buf_valid & ~(|(r_buf_mask & r_busy));
      assign w_busy_nz[w]   = |r_busy;
      assign w_pc[w]        = r_pc;
      assign w_buf_instr[w] = r_buf_instr;
      assign w_buf_mask[w]  = r_buf_mask;
    end
  endgenerate

  // Write to a full buffer that is not being freed by this cycle's issue
  assign w_ovf_set = buf_wr_en & w_buf_valid[buf_warp] & ~(w_fire & (w_grant == buf_warp));

  // Round-robin pointer advances past the warp that just issued
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= {WID{1'b0}};
    end else if (start) begin
      r_rr_ptr <= r_rr_ptr;
    end else if (w_fire) begin
      r_rr_ptr <= w_grant + WID'(1);
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Sticky overflow flag, cleared by reset or launch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (start) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign fetch_pc    = w_pc[fetch_warp];
  assign buf_full    = w_buf_valid;
  assign issue_valid = w_any;
  assign issue_warp  = w_grant;
  assign issue_instr = w_buf_instr[w_grant];
  assign issue_mask  = w_buf_mask[w_grant];
  assign issue_pc    = w_pc[w_grant];
  assign all_done    = ~(|w_active) & ~(|w_busy_nz);
  assign overflow    = r_overflow;

endmodule
